// File: rtl/knight_pkg.sv
// Shared definitions for the Knight host-side command tools.
package knight_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_SNT,
    WAIT_RESP,
    GAP,
    DONE,
    ERR
  } seq_state_t;

  localparam logic [7:0] ACK_POS     = 8'hA5;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_NAK     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam logic [3:0] CMD_CAL     = 4'h2;
  localparam logic [3:0] CMD_MOVE    = 4'h4;
  localparam logic [3:0] CMD_TOUR    = 4'h6;

  // Bits needed to hold values 0..n, never narrower than min_w.
  function automatic int sat_w(input int n, input int min_w);
    int w;
    w = $clog2(n + 1);
    return (w < min_w) ? min_w : w;
  endfunction

endpackage

// File: rtl/cmd_sequencer_store.sv
// Command list storage: DEPTH x 16 slots filled in order from slot 0.
module cmd_store #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [15:0]              wr_data,
  input  logic                     clr,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [15:0]              rd_data,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [15:0] mem [DEPTH];

  // Slot contents are not reset; an empty list is expressed by cnt alone
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[cnt[AW-1:0]] <= wr_data;
  end

  // Write pointer: clear empties the list, writes stop once full
  always_ff @(posedge clk) begin
    if (!rst_n)             cnt <= '0;
    else if (clr)           cnt <= '0;
    else if (wr_en && !full) cnt <= cnt + (AW+1)'(1);
  end

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/cmd_sequencer.sv
// Replays a stored list of Knight commands through RemoteComm, checking each ack.
module cmd_sequencer
  import knight_pkg::*;
#(
  parameter int         DEPTH        = 16,
  parameter int         GAP_CLKS     = 200000,
  parameter int         TIMEOUT_CLKS = 50000000,
  parameter logic [7:0] ACK          = ACK_POS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [15:0]            load_cmd,
  input  logic                   clr,
  input  logic                   start,
  output logic [15:0]            cmd,
  output logic                   snd_cmd,
  input  logic                   cmd_snt,
  input  logic                   resp_rdy,
  input  logic [7:0]             resp,
  output logic                   full,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic [$clog2(DEPTH):0] idx
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = sat_w(TIMEOUT_CLKS, 26);
  localparam int GW = sat_w(GAP_CLKS, 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS);

  seq_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_eff;
  logic [CW-2:0] rd_idx;
  logic [15:0]   rd_data;
  logic [TW-1:0] to_cnt;
  logic [GW-1:0] gap_cnt;
  logic          ctl_st, load_ok, clr_ok, start_ok;
  logic          is_last, to_hit, gap_hit, ack_ok;

  assign ctl_st   = (state == IDLE) || (state == DONE) || (state == ERR);
  assign busy     = !ctl_st;
  assign load_ok  = load && (state == IDLE) && !full;
  assign clr_ok   = clr && ctl_st;
  assign start_ok = start && ctl_st && !clr_ok;
  // A start that coincides with a load sees the list including that load
  assign cnt_eff  = load_ok ? cnt + CW'(1) : cnt;
  assign is_last  = (idx == cnt - CW'(1));
  assign to_hit   = (to_cnt >= TO_LAST);
  assign gap_hit  = (gap_cnt == GAP_LAST);
  assign ack_ok   = (resp == ACK);
  assign rd_idx   = start_ok ? '0 : idx[CW-2:0];

  cmd_store #(.DEPTH(DEPTH)) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (load_ok),
    .wr_data (load_cmd),
    .clr     (clr_ok),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .cnt     (cnt),
    .full    (full)
  );

  // Next-state: qualifying events beat timeout expiry in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (clr_ok)        state_nxt = IDLE;
        else if (start_ok) state_nxt = (cnt_eff == '0) ? DONE : SEND;
      end
      SEND:      state_nxt = WAIT_SNT;
      WAIT_SNT: begin
        // resp_rdy here belongs to an earlier exchange and is ignored
        if (cmd_snt)     state_nxt = WAIT_RESP;
        else if (to_hit) state_nxt = ERR;
      end
      WAIT_RESP: begin
        if (resp_rdy)    state_nxt = ack_ok ? (is_last ? DONE : GAP) : ERR;
        else if (to_hit) state_nxt = ERR;
      end
      GAP:       if (gap_hit) state_nxt = SEND;
      default:   state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Timeout counts every clock from the send pulse on; gap runs GAP_CLKS+1 idle clocks
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      gap_cnt <= '0;
    end else begin
      if ((state == SEND) || (state == WAIT_SNT) || (state == WAIT_RESP)) begin
        if (to_cnt != '1) to_cnt <= to_cnt + TW'(1);
      end else begin
        to_cnt <= '0;
      end
      if ((state == GAP) && !gap_hit) gap_cnt <= gap_cnt + GW'(1);
      else                            gap_cnt <= '0;
    end
  end

  // Registered outputs: send pulse, current command, index and sticky status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snd_cmd  <= 1'b0;
      cmd      <= '0;
      idx      <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      snd_cmd <= (state_nxt == SEND);
      if (clr_ok) begin
        done     <= 1'b0;
        err      <= 1'b0;
        err_code <= ERR_NONE;
      end else if (start_ok) begin
        done     <= (cnt_eff == '0);
        err      <= 1'b0;
        err_code <= ERR_NONE;
        idx      <= '0;
        // Slot 0 may be written in this very cycle, so bypass the array then
        if (cnt_eff != '0) cmd <= (load_ok && (cnt == '0)) ? load_cmd : rd_data;
      end else begin
        case (state)
          WAIT_SNT: begin
            if (!cmd_snt && to_hit) begin
              err      <= 1'b1;
              err_code <= ERR_TIMEOUT;
            end
          end
          WAIT_RESP: begin
            if (resp_rdy) begin
              if (ack_ok) begin
                if (is_last) done <= 1'b1;
                else         idx  <= idx + CW'(1);
              end else begin
                err      <= 1'b1;
                err_code <= ERR_NAK;
              end
            end else if (to_hit) begin
              err      <= 1'b1;
              err_code <= ERR_TIMEOUT;
            end
          end
          GAP:     if (gap_hit) cmd <= rd_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: scripted RemoteComm responder plus a transaction-level model.
module tb_cmd_sequencer;
  import knight_pkg::*;

  localparam int DEPTH = 16;
  localparam int GAP   = 20;
  localparam int TMO   = 1000;
  localparam int CW    = $clog2(DEPTH) + 1;

  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;
  localparam int PH_ERR  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0, clr = 1'b0, start = 1'b0;
  logic [15:0]   load_cmd = '0;
  logic          cmd_snt = 1'b0, resp_rdy = 1'b0;
  logic [7:0]    resp = '0;
  logic [15:0]   cmd;
  logic          snd_cmd, full, busy, done, err;
  logic [1:0]    err_code;
  logic [CW-1:0] idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Responder script, one entry per send of the current run
  logic [7:0] rsp_byte [32];
  bit         rsp_none [32];
  bit         rsp_stale[32];
  int         n_rsp = 0;

  // Model state: list contents, phase of the run and expected outputs
  logic [15:0] m_list[$];
  int          m_phase = PH_IDLE;
  int          m_idx = 0, m_code = 0, m_wait = 0, m_snd_due = -1;
  bit          m_done = 0, m_err = 0, m_cmd_zero = 1, m_valid = 0;

  // Observations used by the literal checks
  logic [15:0] sent[$];
  int          snd_cyc[$];
  int          ack_cyc[$];

  cmd_sequencer #(
    .DEPTH(DEPTH), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TMO), .ACK(ACK_POS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_cmd(load_cmd), .clr(clr),
    .start(start), .cmd(cmd), .snd_cmd(snd_cmd), .cmd_snt(cmd_snt),
    .resp_rdy(resp_rdy), .resp(resp), .full(full), .busy(busy), .done(done),
    .err(err), .err_code(err_code), .idx(idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT samples next edge
  task automatic model_step();
    bit ctl, ld, cl, st;
    if (!rst_n) begin
      m_list.delete();
      m_phase = PH_IDLE; m_idx = 0; m_code = 0; m_wait = 0; m_snd_due = -1;
      m_done = 0; m_err = 0; m_cmd_zero = 1; m_valid = 1;
      return;
    end
    if (!m_valid) return;
    ctl = (m_phase != PH_RUN);
    ld  = load && (m_phase == PH_IDLE) && (m_list.size() < DEPTH);
    cl  = clr && ctl;
    st  = start && ctl && !cl;
    if (cl) begin
      m_list.delete();
      m_phase = PH_IDLE; m_done = 0; m_err = 0; m_code = 0;
    end else begin
      if (ld) m_list.push_back(load_cmd);
      if (st) begin
        m_done = (m_list.size() == 0); m_err = 0; m_code = 0; m_idx = 0; m_wait = 0;
        if (m_list.size() == 0) m_phase = PH_DONE;
        else begin
          m_phase = PH_RUN; m_snd_due = cyc + 1; m_cmd_zero = 0;
        end
      end
    end
    if (m_phase == PH_RUN && !st) begin
      if (m_wait == 1 && cmd_snt) m_wait = 2;
      else if (m_wait == 2 && resp_rdy) begin
        m_wait = 0;
        if (resp == ACK_POS) begin
          ack_cyc.push_back(cyc);
          if (m_idx == m_list.size() - 1) begin
            m_phase = PH_DONE; m_done = 1;
          end else begin
            m_idx++;
            m_snd_due = cyc + GAP + 2;
          end
        end else begin
          m_phase = PH_ERR; m_err = 1; m_code = 1;
        end
      end else if (m_wait != 0 && cyc + 1 >= m_snd_due + TMO) begin
        m_phase = PH_ERR; m_err = 1; m_code = 2; m_wait = 0;
      end
      if (m_phase == PH_RUN && cyc == m_snd_due) m_wait = 1;
    end
  endtask

  // Every cycle: compare DUT outputs with the model, then step the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("snd_cmd", snd_cmd, (m_phase == PH_RUN) && (cyc == m_snd_due));
      if (m_phase == PH_RUN && (cyc == m_snd_due || m_wait != 0))
        chk("cmd", cmd, m_list[m_idx]);
      else if (m_cmd_zero)
        chk("cmd_zero", cmd, 16'h0000);
      chk("busy", busy, m_phase == PH_RUN);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("err_code", err_code, m_code);
      chk("idx", 32'(idx), m_idx);
      chk("full", full, m_list.size() == DEPTH);
      if (snd_cmd) begin
        sent.push_back(cmd);
        snd_cyc.push_back(cyc);
      end
    end
    model_step();
  end

  // RemoteComm stand-in: cmd_snt one clock after the send, then the scripted response
  initial begin : responder
    int k;
    forever begin
      @(posedge clk); #1;
      if (snd_cmd && rst_n) begin
        k = n_rsp % 32;
        n_rsp++;
        @(posedge clk); #1;
        if (rsp_stale[k]) begin
          resp = ACK_POS; resp_rdy = 1'b1;
          @(posedge clk); #1;
          resp_rdy = 1'b0;
        end
        cmd_snt = 1'b1;
        @(posedge clk); #1;
        cmd_snt = 1'b0;
        if (!rsp_none[k]) begin
          resp = rsp_byte[k]; resp_rdy = 1'b1;
          @(posedge clk); #1;
          resp_rdy = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic new_test();
    for (int i = 0; i < 32; i++) begin
      rsp_byte[i] = ACK_POS; rsp_none[i] = 0; rsp_stale[i] = 0;
    end
    n_rsp = 0;
    sent.delete(); snd_cyc.delete(); ack_cyc.delete();
  endtask

  task automatic do_load(input logic [15:0] c);
    load = 1'b1; load_cmd = c;
    tick();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    chk("run_bound", busy, 1'b0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [15:0] tour[4];
    int s, e, n;
    tour[0] = {CMD_CAL, 12'h000};
    tour[1] = {CMD_MOVE, 12'hbf1};
    tour[2] = {CMD_MOVE, 12'h002};
    tour[3] = {CMD_MOVE, 12'h3f2};
    new_test();

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_snd", snd_cmd, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_flags", {done, err, err_code}, 4'b0000);
    chk("rst_full_idx", {full, idx}, '0);
    rst_n = 1'b1;
    tick();

    // Four-command tour, all acked
    new_test();
    for (int i = 0; i < 4; i++) do_load(tour[i]);
    pulse_start();
    wait_idle(2000);
    chk("t1_nsnd", sent.size(), 4);
    for (int i = 0; i < 4 && i < sent.size(); i++) chk("t1_cmd", sent[i], tour[i]);
    for (int i = 0; i + 1 < snd_cyc.size() && i < ack_cyc.size(); i++)
      chk("t1_gap", (snd_cyc[i+1] - ack_cyc[i]) >= GAP, 1'b1);
    chk("t1_done", done, 1'b1);
    chk("t1_err", err, 1'b0);
    chk("t1_idx", 32'(idx), 3);
    pulse_clr();

    // NAK on the second command
    new_test();
    rsp_byte[1] = 8'h5A;
    for (int i = 0; i < 3; i++) do_load(tour[i]);
    pulse_start();
    wait_idle(2000);
    repeat (60) tick();
    chk("t2_err", err, 1'b1);
    chk("t2_code", err_code, 2'd1);
    chk("t2_idx", 32'(idx), 1);
    chk("t2_nsnd", sent.size(), 2);
    pulse_clr();

    // No response: timeout exactly TMO clocks after the send pulse
    new_test();
    rsp_none[0] = 1;
    do_load(16'h4bf1);
    pulse_start();
    chk("t3_snd", snd_cmd, 1'b1);
    s = cyc;
    n = 0;
    while (!err && n < 3000) begin
      tick();
      n++;
    end
    e = cyc;
    chk("t3_clocks", e - s, TMO);
    chk("t3_code", err_code, 2'd2);
    pulse_clr();

    // Stale ack during WAIT_SNT is ignored
    new_test();
    rsp_stale[0] = 1;
    do_load(16'h4002);
    do_load(16'h43f2);
    pulse_start();
    wait_idle(2000);
    chk("t4_nsnd", sent.size(), 2);
    chk("t4_done", done, 1'b1);
    pulse_clr();

    // Full list, dropped 17th load, then empty start and load+start together
    new_test();
    for (int i = 0; i < DEPTH; i++) do_load(16'h6000 + 16'(i));
    chk("t5_full", full, 1'b1);
    do_load(16'hdead);
    chk("t5_full2", full, 1'b1);
    pulse_start();
    wait_idle(3000);
    chk("t5_nsnd", sent.size(), DEPTH);
    if (sent.size() == DEPTH) chk("t5_last", sent[DEPTH-1], 16'h600f);
    pulse_clr();
    new_test();
    pulse_start();
    chk("t5_empty_done", done, 1'b1);
    chk("t5_empty_snd", snd_cmd, 1'b0);
    pulse_clr();
    new_test();
    load = 1'b1; load_cmd = 16'h6001; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    chk("t5_ls_snd", snd_cmd, 1'b1);
    chk("t5_ls_cmd", cmd, 16'h6001);
    wait_idle(2000);
    chk("t5_ls_done", done, 1'b1);
    pulse_clr();

    // Reset while in the gap
    new_test();
    for (int i = 0; i < 3; i++) do_load(tour[i]);
    pulse_start();
    n = 0;
    while (idx != 1 && n < 500) begin
      tick();
      n++;
    end
    chk("t6_in_gap", {busy, snd_cmd}, 2'b10);
    rst_n = 1'b0;
    tick();
    chk("t6_cmd", cmd, 16'h0000);
    chk("t6_outs", {snd_cmd, busy, done, err, err_code, full}, '0);
    chk("t6_idx", 32'(idx), 0);
    rst_n = 1'b1;
    tick();
    pulse_start();
    chk("t6_cnt0_done", done, 1'b1);
    chk("t6_cnt0_snd", snd_cmd, 1'b0);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
